// File: rtl/ysyx_23060191_lsu_pkg.sv
// rtl/ysyx_23060191_lsu_pkg.sv - shared constants and types for the load/store unit
//
// Purpose : datapath width, RV32 load/store funct3 codes, LSU state encoding,
//           access-size decode helper.
// Ports   : none (package).
package ysyx_23060191_lsu_pkg;

   localparam int CPU_WIDTH = 32;

   localparam logic [2:0] LSU_B  = 3'b000;
   localparam logic [2:0] LSU_H  = 3'b001;
   localparam logic [2:0] LSU_W  = 3'b010;
   localparam logic [2:0] LSU_BU = 3'b100;
   localparam logic [2:0] LSU_HU = 3'b101;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_WAIT = 2'd2,
      LSU_DONE = 2'd3
   } lsu_state_t;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } lsu_size_t;

   // funct3[1:0] carries the size; unknown encodings fall back to a word access.
   function automatic lsu_size_t lsu_size(input logic [2:0] funct3);
      case (funct3[1:0])
         2'b00:   return SZ_B;
         2'b01:   return SZ_H;
         default: return SZ_W;
      endcase
   endfunction

endpackage

// File: rtl/ysyx_23060191_lsu_align.sv
// rtl/ysyx_23060191_lsu_align.sv - load extract/extend and store lane replication
//
// Purpose : combinational byte-lane logic shared by loads and stores.
// Ports   : i_wen     - 1 selects the store direction (wdata/wmask), 0 = load
//           i_funct3  - RV32 funct3 of the access
//           i_addr_lo - address bits [1:0]
//           i_wdata   - store data (rs2)
//           i_rdata   - word returned by memory
//           o_wdata   - lane-replicated store data (0 for loads)
//           o_wmask   - byte enables (0 for loads)
//           o_rdata   - extracted and extended load data
module ysyx_23060191_lsu_align #(
   parameter int CPU_WIDTH = 32
) (
   input  logic                 i_wen,
   input  logic [2:0]           i_funct3,
   input  logic [1:0]           i_addr_lo,
   input  logic [CPU_WIDTH-1:0] i_wdata,
   input  logic [CPU_WIDTH-1:0] i_rdata,
   output logic [CPU_WIDTH-1:0] o_wdata,
   output logic [3:0]           o_wmask,
   output logic [CPU_WIDTH-1:0] o_rdata
);
   import ysyx_23060191_lsu_pkg::*;

   lsu_size_t            w_size;
   logic [1:0]           w_off;
   logic [4:0]           w_shift;
   logic [CPU_WIDTH-1:0] w_raw;
   logic                 w_unsigned;

   always_comb begin
      w_size     = lsu_size(i_funct3);
      w_unsigned = (i_funct3 == LSU_BU) || (i_funct3 == LSU_HU);

      // Low address bits below the access size are dropped, so a halfword
      // only looks at addr[1] and a word ignores both bits.
      case (w_size)
         SZ_B:    w_off = i_addr_lo;
         SZ_H:    w_off = {i_addr_lo[1], 1'b0};
         default: w_off = 2'b00;
      endcase
      w_shift = {w_off, 3'b000};
      w_raw   = i_rdata >> w_shift;

      o_rdata = w_raw;
      o_wdata = '0;
      o_wmask = 4'b0000;

      case (w_size)
         SZ_B: begin
            o_rdata = w_unsigned ? {{(CPU_WIDTH-8){1'b0}}, w_raw[7:0]}
                                 : {{(CPU_WIDTH-8){w_raw[7]}}, w_raw[7:0]};
            if (i_wen) begin
               o_wdata = {4{i_wdata[7:0]}};
               o_wmask = 4'b0001 << w_off;
            end
         end
         SZ_H: begin
            o_rdata = w_unsigned ? {{(CPU_WIDTH-16){1'b0}}, w_raw[15:0]}
                                 : {{(CPU_WIDTH-16){w_raw[15]}}, w_raw[15:0]};
            if (i_wen) begin
               o_wdata = {2{i_wdata[15:0]}};
               o_wmask = 4'b0011 << w_off;
            end
         end
         default: begin
            if (i_wen) begin
               o_wdata = i_wdata;
               o_wmask = 4'b1111;
            end
         end
      endcase
   end

endmodule

// File: rtl/ysyx_23060191_lsu.sv
// rtl/ysyx_23060191_lsu.sv - multi-cycle load/store unit feeding writeback
//
// Purpose : accepts one op from EXU, issues a word-aligned data-memory request,
//           waits for the response, extends load data and hands the result
//           to WBU with a valid/ready handshake.
// Optional: YSYX_23060191_LSU_MISALIGN_CHECK_EN - flag misaligned H/W accesses
//           at accept and complete them without touching memory.
// Ports   : clk, rst (async, active high)
//           in_valid/in_ready, in_ren, in_wen, in_funct3, in_addr, in_wdata,
//           in_exu_res                          - op from EXU
//           dmem_req_valid/ready, dmem_req_wen, dmem_req_addr, dmem_req_wdata,
//           dmem_req_wmask                      - memory request
//           dmem_resp_valid, dmem_resp_rdata    - memory response / ack
//           out_valid/out_ready, lsu_res, load_en, exu_res, misalign - to WBU
module ysyx_23060191_lsu #(
   parameter int CPU_WIDTH = ysyx_23060191_lsu_pkg::CPU_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_ren,
   input  logic                 in_wen,
   input  logic [2:0]           in_funct3,
   input  logic [CPU_WIDTH-1:0] in_addr,
   input  logic [CPU_WIDTH-1:0] in_wdata,
   input  logic [CPU_WIDTH-1:0] in_exu_res,
   output logic                 dmem_req_valid,
   input  logic                 dmem_req_ready,
   output logic                 dmem_req_wen,
   output logic [CPU_WIDTH-1:0] dmem_req_addr,
   output logic [CPU_WIDTH-1:0] dmem_req_wdata,
   output logic [3:0]           dmem_req_wmask,
   input  logic                 dmem_resp_valid,
   input  logic [CPU_WIDTH-1:0] dmem_resp_rdata,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CPU_WIDTH-1:0] lsu_res,
   output logic                 load_en,
   output logic [CPU_WIDTH-1:0] exu_res,
   output logic                 misalign
);
   import ysyx_23060191_lsu_pkg::*;

   lsu_state_t           r_state;
   logic                 r_in_ready;
   logic                 r_req_valid;
   logic                 r_out_valid;
   logic                 r_load_en;
   logic                 r_wen;
   logic [2:0]           r_funct3;
   logic [CPU_WIDTH-1:0] r_addr;
   logic [CPU_WIDTH-1:0] r_wdata;
   logic [CPU_WIDTH-1:0] r_exu_res;
   logic [CPU_WIDTH-1:0] r_lsu_res;

   logic [CPU_WIDTH-1:0] w_req_wdata;
   logic [3:0]           w_req_wmask;
   logic [CPU_WIDTH-1:0] w_load_data;
   logic                 w_misalign;

`ifdef YSYX_23060191_LSU_MISALIGN_CHECK_EN
   logic r_misalign;

   always_comb begin
      w_misalign = 1'b0;
      if (in_ren || in_wen) begin
         case (lsu_size(in_funct3))
            SZ_B:    w_misalign = 1'b0;
            SZ_H:    w_misalign = in_addr[0];
            default: w_misalign = (in_addr[1:0] != 2'b00);
         endcase
      end
   end

   assign misalign = r_misalign;
`else
   assign w_misalign = 1'b0;
   assign misalign   = 1'b0;
`endif

   // The align block works from latched fields: the request side stays stable
   // through REQ, and the load side sees the same funct3/addr during WAIT.
   ysyx_23060191_lsu_align #(
      .CPU_WIDTH(CPU_WIDTH)
   ) u_align (
      .i_wen     (r_wen),
      .i_funct3  (r_funct3),
      .i_addr_lo (r_addr[1:0]),
      .i_wdata   (r_wdata),
      .i_rdata   (dmem_resp_rdata),
      .o_wdata   (w_req_wdata),
      .o_wmask   (w_req_wmask),
      .o_rdata   (w_load_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= LSU_IDLE;
         r_in_ready  <= 1'b1;
         r_req_valid <= 1'b0;
         r_out_valid <= 1'b0;
         r_load_en   <= 1'b0;
         r_wen       <= 1'b0;
         r_funct3    <= 3'b000;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_exu_res   <= '0;
         r_lsu_res   <= '0;
`ifdef YSYX_23060191_LSU_MISALIGN_CHECK_EN
         r_misalign  <= 1'b0;
`endif
      end else begin
         case (r_state)
            LSU_IDLE: begin
               if (in_valid) begin
                  // ren&wen together is a store: r_wen alone decides direction.
                  r_wen      <= in_wen;
                  r_funct3   <= in_funct3;
                  r_addr     <= in_addr;
                  r_wdata    <= in_wdata;
                  r_exu_res  <= in_exu_res;
                  r_in_ready <= 1'b0;
`ifdef YSYX_23060191_LSU_MISALIGN_CHECK_EN
                  r_misalign <= w_misalign;
`endif
                  if (w_misalign || !(in_ren || in_wen)) begin
                     r_load_en   <= 1'b0;
                     r_lsu_res   <= '0;
                     r_out_valid <= 1'b1;
                     r_state     <= LSU_DONE;
                  end else begin
                     r_req_valid <= 1'b1;
                     r_state     <= LSU_REQ;
                  end
               end
            end
            LSU_REQ: begin
               if (dmem_req_ready) begin
                  r_req_valid <= 1'b0;
                  r_state     <= LSU_WAIT;
               end
            end
            LSU_WAIT: begin
               if (dmem_resp_valid) begin
                  if (r_wen) begin
                     r_load_en <= 1'b0;
                     r_lsu_res <= '0;
                  end else begin
                     r_load_en <= 1'b1;
                     r_lsu_res <= w_load_data;
                  end
                  r_out_valid <= 1'b1;
                  r_state     <= LSU_DONE;
               end
            end
            default: begin
               // No accept in this cycle: the next op waits for IDLE.
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= LSU_IDLE;
               end
            end
         endcase
      end
   end

   assign in_ready       = r_in_ready;
   assign dmem_req_valid = r_req_valid;
   assign dmem_req_wen   = r_wen;
   assign dmem_req_addr  = {r_addr[CPU_WIDTH-1:2], 2'b00};
   assign dmem_req_wdata = w_req_wdata;
   assign dmem_req_wmask = w_req_wmask;
   assign out_valid      = r_out_valid;
   assign lsu_res        = r_lsu_res;
   assign load_en        = r_load_en;
   assign exu_res        = r_exu_res;

endmodule

// File: doc/ysyx_23060191_lsu.md
Name: ysyx_23060191_lsu

Overview:
Multi-cycle load/store unit directly upstream of the writeback stage. It accepts one memory op per transaction from EXU, issues a word-aligned request on the data-memory bus, and waits for the response. For loads it extracts and extends the sub-word data. It presents lsu_res/load_en plus the pass-through exu_res to the writeback mux with a valid/ready handshake.

Parameters:
CPU_WIDTH, 32, datapath and address width (only 32 supported)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  EXU presents an op
in_ready  out  1  LSU can accept (IDLE only)
in_ren  in  1  op is a load
in_wen  in  1  op is a store
in_funct3  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
in_addr  in  CPU_WIDTH  effective address
in_wdata  in  CPU_WIDTH  store data (rs2)
in_exu_res  in  CPU_WIDTH  EXU result, carried to output
dmem_req_valid  out  1  memory request pending
dmem_req_ready  in  1  memory accepts request
dmem_req_wen  out  1  1 = write
dmem_req_addr  out  CPU_WIDTH  {addr[31:2],2'b00}
dmem_req_wdata  out  CPU_WIDTH  lane-replicated store data
dmem_req_wmask  out  4  byte enables (0 for reads)
dmem_resp_valid  in  1  response/ack (loads and stores)
dmem_resp_rdata  in  CPU_WIDTH  read word
out_valid  out  1  result ready for WBU
out_ready  in  1  WBU consumes
lsu_res  out  CPU_WIDTH  extended load data (0 for non-loads)
load_en  out  1  selects lsu_res in WBU
exu_res  out  CPU_WIDTH  registered in_exu_res
misalign  out  1  misaligned access flag (optional feature)

Behaviour:
- Reset: state IDLE; in_ready=1 after reset release; dmem_req_valid=0, out_valid=0, load_en=0, misalign=0; lsu_res, exu_res, dmem_req_* data regs = 0.
- States: IDLE, REQ, WAIT, DONE (2-bit encoding).
- IDLE: in_ready=1. On in_valid, latch all in_* fields. If ren|wen, go to REQ. Otherwise go to DONE with load_en=0 and lsu_res=0 (pass-through, out_valid the next cycle).
- REQ: dmem_req_valid=1, fields stable. On dmem_req_ready, go to WAIT. The request may not be withdrawn.
- WAIT: on dmem_resp_valid, go to DONE. For a load, latch the extended data into lsu_res and set load_en=1. For a store, discard rdata and set load_en=0. dmem_resp_valid outside WAIT is ignored.
- DONE: out_valid=1, outputs held stable. On out_ready, go to IDLE. No new accept in the same cycle, so throughput is at most 1 op per 2 cycles.
- Minimum load latency: accept at T, request at T+1 (ready same cycle), response at T+2, out_valid at T+3.
- Load extraction: shift = addr[1:0]*8; raw = rdata>>shift.
  - LB: sign-extend raw[7:0]; LBU: zero-extend raw[7:0].
  - LH: sign-extend raw[15:0]; LHU: zero-extend raw[15:0].
  - LW: raw.
  - Other funct3: treated as LW.
- Store lanes:
  - SB: wdata={4{wdata[7:0]}}, wmask=4'b0001<<addr[1:0].
  - SH: wdata={2{wdata[15:0]}}, wmask=4'b0011<<{addr[1],1'b0}.
  - SW: wdata as-is, wmask=4'b1111.
- ren&wen both set: handled as a store.
- Without the optional feature, low address bits beyond the access size are ignored: H uses addr[1] only, W uses neither.
- Asynchronous rst mid-transaction returns to IDLE immediately and abandons any outstanding request. The memory model must drop any later response.

Optional Feature:
Macro YSYX_23060191_LSU_MISALIGN_CHECK_EN.
- Defined: halfword with addr[0]=1, or word with addr[1:0]!=0, is detected at accept. It skips REQ/WAIT and goes straight to DONE with misalign=1, load_en=0, lsu_res=0. No dmem request is issued.
- Undefined: misalign tied to 0, and the truncation rule above applies.

Decomposition:
- Shared defines package holds:
  - CPU_WIDTH
  - funct3 constants (LSU_B/H/W/BU/HU)
  - LSU state encoding
- One natural combinational sub-module, ysyx_23060191_lsu_align, covers load extract/extend, store lane replication and wmask generation. It is shared by both directions via a ren/wen select.

Test Plan:
- Reset check: assert rst mid-sim → next cycle state IDLE, in_ready=1, dmem_req_valid=0, out_valid=0.
- LB at addr 0x80000003, rdata 0x80FF_1234 → dmem_req_addr=0x80000000, wmask=0. lsu_res=0xFFFF_FF80, load_en=1, out_valid 3 cycles after accept with ready held high.
- LHU at 0x80000002, rdata 0xBEEF_0000 → lsu_res=0x0000_BEEF.
- LH at the same address → lsu_res=0xFFFF_BEEF.
- SB at 0x80000001, wdata 0x0000_00AB → dmem_req_wdata=0xABAB_ABAB, wmask=0010, dmem_req_wen=1. After ack, load_en=0, exu_res passed through.
- Backpressure: dmem_req_ready low 3 cycles, then out_ready low 2 cycles → request fields and outputs stay stable, and in_ready stays 0 throughout.
- Non-memory op: in_exu_res=0x1234, ren=wen=0 → no dmem_req_valid, out_valid at T+1, load_en=0, exu_res=0x1234.
- With the macro defined, LW at 0x80000002 → no request, misalign=1, out_valid at T+1.
